// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: holds instr/pc pairs while decode
// stalls, replays them in order, optional zero-latency bypass when empty.
module fetch_queue #(
   parameter int WIDTH  = 16,
   parameter int PC_W   = 16,
   parameter int DEPTH  = 4,
   parameter int BYPASS = 1,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_instr,
   input  logic [PC_W-1:0]  in_pc,
   output logic             in_ready,
   input  logic             stall,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_instr,
   output logic [PC_W-1:0]  out_pc,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam bit BYP   = (BYPASS != 0);

   logic [WIDTH-1:0] mem_instr [DEPTH];
   logic [PC_W-1:0]  mem_pc    [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             bypass_hit;
   logic             push;
   logic             pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign in_ready = !full;

   assign bypass_hit = BYP && empty && in_valid && !flush;
   assign out_valid  = !flush && (!empty || bypass_hit);

   // A bypassed word is consumed directly unless decode is stalled, then it is stored
   assign push = in_valid && in_ready && !flush && !(bypass_hit && !stall);
   assign pop  = out_valid && !stall && !flush && !empty;

   always_comb begin
      out_instr = mem_instr[rd_ptr];
      out_pc    = mem_pc[rd_ptr];
      if (bypass_hit) begin
         out_instr = in_instr;
         out_pc    = in_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // Storage is intentionally left out of reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= in_instr;
         mem_pc[wr_ptr]    <= in_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue; a bypass build and a non-bypass
// build see the same stimulus and are each checked against a queue model.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_instr = '0;
   logic [15:0] in_pc = '0;
   logic        stall = 1'b0;

   logic        rdy1, ov1, full1, empty1;
   logic [15:0] oi1, op1;
   logic [2:0]  cnt1;
   logic        rdy0, ov0, full0, empty0;
   logic [15:0] oi0, op0;
   logic [2:0]  cnt0;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] q1[$];
   logic [31:0] q0[$];

   always #5 clk = ~clk;

   fetch_queue #(.WIDTH(16), .PC_W(16), .DEPTH(DEPTH), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
      .in_instr(in_instr), .in_pc(in_pc), .in_ready(rdy1), .stall(stall),
      .out_valid(ov1), .out_instr(oi1), .out_pc(op1), .count(cnt1),
      .full(full1), .empty(empty1));

   fetch_queue #(.WIDTH(16), .PC_W(16), .DEPTH(DEPTH), .BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
      .in_instr(in_instr), .in_pc(in_pc), .in_ready(rdy0), .stall(stall),
      .out_valid(ov0), .out_instr(oi0), .out_pc(op0), .count(cnt0),
      .full(full0), .empty(empty0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_one(input string nm, input bit byp, input logic [31:0] q[$],
                            input logic ov, input logic [15:0] oi, input logic [15:0] op,
                            input logic [2:0] cnt, input logic fu, input logic em,
                            input logic rdy);
      logic        ev;
      logic [31:0] ed;
      ev = !flush && (q.size() > 0 || (byp && in_valid));
      chk({nm, ".out_valid"}, 32'(ov), 32'(ev));
      if (ev) begin
         ed = (q.size() > 0) ? q[0] : {in_instr, in_pc};
         chk({nm, ".out_instr"}, 32'(oi), 32'(ed[31:16]));
         chk({nm, ".out_pc"}, 32'(op), 32'(ed[15:0]));
      end
      chk({nm, ".count"}, 32'(cnt), 32'(q.size()));
      chk({nm, ".full"}, 32'(fu), 32'(q.size() == DEPTH));
      chk({nm, ".empty"}, 32'(em), 32'(q.size() == 0));
      chk({nm, ".in_ready"}, 32'(rdy), 32'(q.size() != DEPTH));
   endtask

   task automatic check_all;
      check_one("byp1", 1'b1, q1, ov1, oi1, op1, cnt1, full1, empty1, rdy1);
      check_one("byp0", 1'b0, q0, ov0, oi0, op0, cnt0, full0, empty0, rdy0);
   endtask

   // Next queue contents after one clock edge, from the current inputs
   task automatic model_next(input bit byp, input logic [31:0] q[$], output logic [31:0] r[$]);
      bit consume, do_pop, do_push;
      r = q;
      if (flush) begin
         r.delete();
      end else begin
         consume = byp && q.size() == 0 && in_valid && !stall;
         do_pop  = q.size() > 0 && !stall;
         do_push = in_valid && q.size() < DEPTH && !consume;
         if (do_pop) void'(r.pop_front());
         if (do_push) r.push_back({in_instr, in_pc});
      end
   endtask

   task automatic cyc(input bit v, input logic [15:0] i, input logic [15:0] p,
                      input bit s, input bit f);
      logic [31:0] n1[$];
      logic [31:0] n0[$];
      in_valid = v; in_instr = i; in_pc = p; stall = s; flush = f;
      #1;
      check_all();
      model_next(1'b1, q1, n1);
      model_next(1'b0, q0, n0);
      @(posedge clk);
      q1 = n1;
      q0 = n0;
      @(negedge clk);
   endtask

   initial begin
      #1;
      chk("reset.count", 32'(cnt1), 32'd0);
      chk("reset.empty", 32'(empty1), 32'd1);
      chk("reset.out_valid", 32'(ov1), 32'd0);
      chk("reset.in_ready", 32'(rdy1), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // bypass: empty, no stall
      cyc(1, 16'h1234, 16'h0002, 0, 0);
      chk("bypass.count_next", 32'(cnt1), 32'd0);
      cyc(0, 16'h0, 16'h0, 0, 0);
      cyc(0, 16'h0, 16'h0, 0, 0);

      // BYPASS=0 latency
      cyc(1, 16'h5555, 16'h0040, 0, 0);
      chk("nobyp.out_instr_next", 32'(oi0), 32'h5555);
      cyc(0, 16'h0, 16'h0, 0, 0);
      chk("nobyp.empty_after_pop", 32'(empty0), 32'd1);

      // fill to full, then drain
      for (int k = 0; k < 5; k++) cyc(1, 16'hA000 + 16'(k), 16'h0100 + 16'(k), 1, 0);
      chk("fill.full", 32'(full1), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("drain.order", 32'(oi1), 32'hA000 + 32'(k));
         cyc(0, 16'h0, 16'h0, 0, 0);
      end
      chk("drain.empty", 32'(empty1), 32'd1);

      // wrap-around at count 2
      cyc(1, 16'hB000, 16'h0200, 1, 0);
      cyc(1, 16'hB001, 16'h0201, 1, 0);
      for (int k = 2; k < 12; k++) begin
         cyc(1, 16'hB000 + 16'(k), 16'h0200 + 16'(k), 0, 0);
         chk("wrap.count", 32'(cnt1), 32'd2);
      end
      cyc(0, 16'h0, 16'h0, 0, 0);
      cyc(0, 16'h0, 16'h0, 0, 0);

      // flush with 3 stored and a same-cycle push
      for (int k = 0; k < 3; k++) cyc(1, 16'hC000 + 16'(k), 16'h0300 + 16'(k), 1, 0);
      cyc(1, 16'hDEAD, 16'h0333, 1, 1);
      chk("flush.count", 32'(cnt1), 32'd0);
      cyc(0, 16'h0, 16'h0, 0, 0);

      // asynchronous reset mid-cycle with 3 stored
      for (int k = 0; k < 3; k++) cyc(1, 16'hE000 + 16'(k), 16'h0400 + 16'(k), 1, 0);
      in_valid = 1'b0; stall = 1'b1;
      #2 rst = 1'b1;
      #1;
      q1.delete();
      q0.delete();
      chk("rst_async.count", 32'(cnt1), 32'd0);
      chk("rst_async.empty", 32'(empty1), 32'd1);
      chk("rst_async.out_valid", 32'(ov1), 32'd0);
      check_all();
      #1 rst = 1'b0;
      @(negedge clk);
      cyc(1, 16'h8041, 16'h0010, 1, 0);
      chk("rst_after.head", 32'(oi1), 32'h8041);
      chk("rst_after.head_pc", 32'(op1), 32'h0010);
      cyc(0, 16'h0, 16'h0, 0, 1);

      // random traffic
      for (int k = 0; k < 400; k++)
         cyc(($urandom % 4) != 0, 16'($urandom), 16'($urandom), ($urandom % 3) == 0,
             ($urandom % 25) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction buffer between instruction fetch and decode. It captures fetched instruction/PC pairs while decode is stalled and replays them in order once the stall releases. It generalises the fixed stall buffer to configurable data width, PC width and depth, and adds three things that buffer lacks: an optional empty-queue bypass, explicit occupancy/full/empty status, and a ready handshake back to fetch. A flush from the branch-resolution logic discards all buffered entries in one cycle.

## Interface
- `WIDTH`, default 16: instruction word width in bits.
- `PC_W`, default 16: PC width in bits.
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥ 2.
- `BYPASS`, default 1:
  - 1: when the queue is empty, the input is presented combinationally on the output.
  - 0: every entry passes through storage, giving at least one cycle of latency.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of `count`. Derived; not to be overridden.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: discards all entries and any same-cycle push.
- `in_valid`  in  1: fetch presents a word.
- `in_instr`  in  WIDTH: fetched instruction.
- `in_pc`  in  PC_W: PC of `in_instr`.
- `in_ready`  out  1: queue accepts a push this cycle; equals `!full`.
- `stall`  in  1: decode cannot consume this cycle.
- `out_valid`  out  1: `out_instr`/`out_pc` are meaningful.
- `out_instr`  out  WIDTH: oldest instruction.
- `out_pc`  out  PC_W: PC of `out_instr`.
- `count`  out  CNT_W: number of stored entries, 0..DEPTH.
- `full`  out  1: `count == DEPTH`.
- `empty`  out  1: `count == 0`.

## Operation
- **Storage:**
  - Circular array of DEPTH entries, each `{instr, pc}`.
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap naturally modulo DEPTH.
  - `count` is a separate register.
- **Push:** `in_valid && in_ready && !flush`, excluding the bypass-consume case below.
- **Pop:** `out_valid && !stall && !flush && !empty`.
- **Bypass path** (BYPASS=1):
  - Applies when `empty && in_valid && !flush`.
  - Outputs: `out_valid`=1, `out_instr`=`in_instr`, `out_pc`=`in_pc`.
  - If `!stall`, the word is consumed directly: no write occurs and `count` stays 0.
  - If `stall`, the word is written (normal push).
- **Output, non-empty:** `out_valid`=1 and the output shows the entry at `rd_ptr`, independent of the input.
- **Output, empty:** `out_valid`=1 only on the bypass path, otherwise 0.
- **Simultaneous push and pop:** both pointers advance and `count` is unchanged. Legal at any count < DEPTH.
- **Push when full:** `in_ready`=0. The word is not stored and the state is unchanged. Fetch must hold the word or drop it; that is its responsibility.
- **Flush:**
  - Next edge: `wr_ptr`=`rd_ptr`=0 and `count`=0.
  - Flush has priority over push and pop in the same cycle.
  - `out_valid` is forced to 0 in the flush cycle.
- **Reset** (asynchronous, any time, including mid-fill):
  - Pointers and `count` go to 0 immediately.
  - Storage contents are not cleared.
- **Output values under reset:** `count`=0, `empty`=1, `full`=0, `in_ready`=1, `out_valid`=0 (with `in_valid` low).
- `out_instr`/`out_pc` are don't-care whenever `out_valid`=0.

## Timing
- Latency, BYPASS=1, empty, no stall: 0 cycles (combinational pass-through).
- Latency, stored entry: a word pushed at edge N is visible on the output in the cycle after edge N, provided it is oldest.
- Latency, BYPASS=0: minimum 1 cycle; `out_valid` rises the cycle after the first push.
- `count`, `full` and `empty` are registered-state derived and change only at edges or on reset assertion.
- Combinational paths:
  - `in_*`→`out_*` exists only when BYPASS=1.
  - `stall`→`in_ready` does not exist.
- Throughput: one push and one pop per cycle.
- With DEPTH ≥ 2 and stall deasserted, sustained fetch causes no bubbles.

## Test plan
- **Reset:** assert `rst` mid-cycle with 3 entries stored → `count`=0, `empty`=1 and `out_valid`=0 immediately, without waiting for a clock edge; after release, the next push of 0x8041 @ pc 0x0010 is the output head.
- **Bypass** (BYPASS=1): empty queue, `stall`=0, `in_instr`=0x1234 @ 0x0002 → same cycle `out_valid`=1, `out_instr`=0x1234; next cycle `count`=0.
- **Fill to full** (DEPTH=4): `stall`=1, push 0xA000..0xA004 on 5 consecutive cycles → `count`=4 and `full`=1 after the 4th; `in_ready`=0 on the 5th, and 0xA004 is not stored; release `stall` → pops 0xA000..0xA003 in order, then `empty`=1.
- **Wrap-around:** 10 cycles of simultaneous push/pop at `count`=2, with incrementing data → output order strictly matches input order across a pointer wrap; `count` stays 2 throughout.
- **Flush:** 3 stored entries plus `in_valid` and `flush` in the same cycle → next cycle `count`=0 and `out_valid`=0; the flushed-cycle word never appears at the output.
- **BYPASS=0 build:** empty queue, push 0x5555 with `stall`=0 → `out_valid`=0 that cycle; next cycle `out_instr`=0x5555, then pop → `empty`=1.
